// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// default datapath width and the sequential PC increment.
package ifetch_unit_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned PC_STEP      = 4;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,  // may issue a request when credit allows
        S_WAIT  = 2'd1,  // one request outstanding, waiting for its response
        S_DROP  = 2'd2,  // outstanding response belongs to a squashed path
        S_FAULT = 2'd3   // misaligned PC seen; parked until redirect
    } fetch_state_t;

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry FIFO of {instruction, pc} pairs between fetch and decode.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, push_data,
//   push_pc            write one entry (never issued when full)
//   pop                remove head (caller qualifies with head_valid)
//   flush              empty the FIFO; wins over push and pop
//   count              current occupancy 0..2
//   head_valid/data/pc oldest entry; data/pc read as 0 when empty
module ifetch_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic [W-1:0] push_pc,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic [W-1:0] head_pc
);

    logic [W-1:0] data_q [2];
    logic [W-1:0] pc_q   [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                pc_q[wr_ptr]   <= push_pc;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head_data  = head_valid ? data_q[rd_ptr] : '0;
    assign head_pc    = head_valid ? pc_q[rd_ptr]   : '0;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage. Reads the PC register, issues one word request at
// a time to instruction memory, and buffers {instruction, pc} for decode.
// Drives the PC register load: pc+4 on each accepted request, or redirect_pc.
// Ports:
//   pc_in / pc_load / pc_next           PC register interface
//   redirect_valid / redirect_pc        branch or jump taken this cycle
//   imem_req_valid/ready/addr           fetch request channel
//   imem_rsp_valid/data                 single-cycle response pulse
//   inst_valid/ready/data/pc            decode handshake (buffer head)
//   fetch_misalign                      sticky misaligned-PC flag
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_next,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_misalign
);

    localparam logic [1:0] BUF_FULL = 2'(BUF_DEPTH);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] req_pc_q;
    logic            misalign_q;

    logic [1:0]      buf_count;
    logic            buf_valid;
    logic            push_c;
    logic            req_valid_c;
    logic            req_accept;
    logic            load_c;
    logic [XLEN-1:0] next_c;
    logic            credit;
    logic            misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            req_pc_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_accept) begin
                req_pc_q <= pc_in;
            end
            if (redirect_valid) begin
                misalign_q <= 1'b0;
            end else if (state_q == S_REQ && misaligned) begin
                misalign_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_valid_c = 1'b0;
        req_accept  = 1'b0;
        push_c      = 1'b0;
        load_c      = 1'b0;
        next_c      = '0;
        credit      = (buf_count < BUF_FULL) && (state_q == S_REQ);
        misaligned  = (pc_in[1:0] != 2'b00);

        // Redirect reloads the PC from any state and suppresses the +4 path.
        if (redirect_valid) begin
            load_c = 1'b1;
            next_c = redirect_pc;
        end

        case (state_q)
            S_REQ: begin
                if (!redirect_valid) begin
                    if (misaligned) begin
                        state_d = S_FAULT;
                    end else if (credit) begin
                        req_valid_c = 1'b1;
                        if (imem_req_ready) begin
                            req_accept = 1'b1;
                            load_c     = 1'b1;
                            next_c     = pc_in + XLEN'(PC_STEP);
                            state_d    = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    push_c  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                // The squashed response retires the outstanding request even
                // if another redirect lands in the same cycle.
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            S_FAULT: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    ifetch_buf #(
        .W (XLEN)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_c),
        .push_data  (imem_rsp_data),
        .push_pc    (req_pc_q),
        .pop        (buf_valid & inst_ready),
        .flush      (redirect_valid),
        .count      (buf_count),
        .head_valid (buf_valid),
        .head_data  (inst_data),
        .head_pc    (inst_pc)
    );

    // Combinational outputs are held at 0 while reset is asserted.
    assign imem_req_valid = rst_n & req_valid_c;
    assign imem_req_addr  = rst_n ? pc_in : '0;
    assign pc_load        = rst_n & load_c;
    assign pc_next        = rst_n ? next_c : '0;
    assign inst_valid     = buf_valid;
    assign fetch_misalign = misalign_q;

endmodule
